// File: rtl/ff_chk_pkg.sv
// ff_chk_pkg: shared state encoding and mismatch-vector bit positions for ff_triple_checker.
package ff_chk_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2, DONE = 2'd3} state_t;
   localparam int SR_BIT = 0;
   localparam int JK_BIT = 1;
   localparam int T_BIT  = 2;
endpackage

// File: rtl/ff_triple_checker_sat_counter.sv
// sat_counter: counter that sticks at all-ones; clr beats inc.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);
   always_ff @(posedge clk)
      if (reset || clr) cnt <= '0;
      else if (inc && cnt != '1) cnt <= cnt + W'(1);
endmodule

// File: rtl/ff_triple_checker.sv
// ff_triple_checker: checks SR/JK/T-derived D flops against a local reference, counts
// mismatches, latches the first failure and sequences runs with an IDLE/RUN/HALT/DONE FSM.
module ff_triple_checker
   import ff_chk_pkg::*;
#(
   parameter int CNT_W        = 16,
   parameter int RUN_LEN      = 0,
   parameter int HALT_ON_FAIL = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             d_in,
   input  logic             q_sr,
   input  logic             q_jk,
   input  logic             q_t,
   output logic             q_vote,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [2:0]       fail_mask,
   output logic [CNT_W-1:0] fail_cycle,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] mis_cnt_sr,
   output logic [CNT_W-1:0] mis_cnt_jk,
   output logic [CNT_W-1:0] mis_cnt_t
);
   state_t     state, state_nx;
   logic       q_ref;
   logic [2:0] m;
   logic       cmp, any, last;

   // q_ref shares clock and reset with the monitored flops, so it lines up with their Q
   always_ff @(posedge clk)
      q_ref <= reset ? 1'b0 : d_in;

   assign m    = (state == RUN) ? ({q_t, q_jk, q_sr} ^ {3{q_ref}}) : 3'b000;
   assign any  = |m;
   assign cmp  = (state == RUN) && !start && !stop;
   assign last = (RUN_LEN != 0) && (cycle_cnt == CNT_W'(RUN_LEN - 1));

   always_ff @(posedge clk)
      state <= reset ? IDLE : state_nx;

   always_comb
      state_nx = start                       ? RUN   :
                 (state != RUN)              ? state :
                 stop                        ? IDLE  :
                 (HALT_ON_FAIL != 0 && any)  ? HALT  :
                 last                        ? DONE  : RUN;

   always_comb begin
      busy   = (state == RUN);
      q_vote = (q_sr & q_jk) | (q_sr & q_t) | (q_jk & q_t);
   end

   always_ff @(posedge clk)
      done <= !reset && (state == RUN) && (state_nx == DONE);

   always_ff @(posedge clk)
      if (reset || start) begin
         error      <= 1'b0;
         fail_mask  <= 3'b000;
         fail_cycle <= '0;
      end else if (cmp && any && !error) begin
         error      <= 1'b1;
         fail_mask  <= m;
         fail_cycle <= cycle_cnt;
      end

   sat_counter #(.W(CNT_W)) u_cyc (.clk(clk), .reset(reset), .clr(start), .inc(cmp), .cnt(cycle_cnt));
   sat_counter #(.W(CNT_W)) u_sr  (.clk(clk), .reset(reset), .clr(start), .inc(cmp && m[SR_BIT]), .cnt(mis_cnt_sr));
   sat_counter #(.W(CNT_W)) u_jk  (.clk(clk), .reset(reset), .clr(start), .inc(cmp && m[JK_BIT]), .cnt(mis_cnt_jk));
   sat_counter #(.W(CNT_W)) u_t   (.clk(clk), .reset(reset), .clr(start), .inc(cmp && m[T_BIT]), .cnt(mis_cnt_t));
endmodule

// File: tb/tb_ff_triple_checker.sv
// tb_ff_triple_checker: three parameterisations checked in lockstep against a cycle-level model
module tb_ff_triple_checker;
  logic clk = 0, reset = 1, start = 0, stop = 0, d_in = 0, q_sr = 0, q_jk = 0, q_t = 0;
  always #5 clk = ~clk;
  logic        v0, b0, dn0, e0, v1, b1, dn1, e1, v2, b2, dn2, e2;
  logic [2:0]  fm0, fm1, fm2;
  logic [15:0] fc0, cc0, ms0, mj0, mt0, fc1, cc1, ms1, mj1, mt1;
  logic [3:0]  fc2, cc2, ms2, mj2, mt2;
  ff_triple_checker #(.CNT_W(16), .RUN_LEN(5), .HALT_ON_FAIL(1)) u0 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .d_in(d_in), .q_sr(q_sr), .q_jk(q_jk), .q_t(q_t),
    .q_vote(v0), .busy(b0), .done(dn0), .error(e0), .fail_mask(fm0), .fail_cycle(fc0), .cycle_cnt(cc0),
    .mis_cnt_sr(ms0), .mis_cnt_jk(mj0), .mis_cnt_t(mt0));
  ff_triple_checker #(.CNT_W(16), .RUN_LEN(0), .HALT_ON_FAIL(0)) u1 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .d_in(d_in), .q_sr(q_sr), .q_jk(q_jk), .q_t(q_t),
    .q_vote(v1), .busy(b1), .done(dn1), .error(e1), .fail_mask(fm1), .fail_cycle(fc1), .cycle_cnt(cc1),
    .mis_cnt_sr(ms1), .mis_cnt_jk(mj1), .mis_cnt_t(mt1));
  ff_triple_checker #(.CNT_W(4), .RUN_LEN(0), .HALT_ON_FAIL(0)) u2 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .d_in(d_in), .q_sr(q_sr), .q_jk(q_jk), .q_t(q_t),
    .q_vote(v2), .busy(b2), .done(dn2), .error(e2), .fail_mask(fm2), .fail_cycle(fc2), .cycle_cnt(cc2),
    .mis_cnt_sr(ms2), .mis_cnt_jk(mj2), .mis_cnt_t(mt2));
  logic [86:0] act [3];
  assign act[0] = {b0, dn0, e0, fm0, fc0, cc0, ms0, mj0, mt0, v0};
  assign act[1] = {b1, dn1, e1, fm1, fc1, cc1, ms1, mj1, mt1, v1};
  assign act[2] = {b2, dn2, e2, fm2, 12'd0, fc2, 12'd0, cc2, 12'd0, ms2, 12'd0, mj2, 12'd0, mt2, v2};
  int rl [3] = '{5, 0, 0};
  int hf [3] = '{1, 0, 0};
  int mx [3] = '{65535, 65535, 15};
  int mode [3], cyc [3], fc [3], mis [3][3];
  logic dn [3], er [3];
  logic [2:0] fm [3];
  logic prev_d = 0;
  logic [86:0] qe [3][$];
  int checks = 0, errors = 0;
  always @(negedge clk)
    if (b0) assert (!$isunknown({d_in, q_sr, q_jk, q_t}));
  task automatic step();
    logic [2:0] m;
    int old;
    for (int k = 0; k < 3; k++) begin
      dn[k] = 0;
      m = (mode[k] == 1) ? ({q_t, q_jk, q_sr} ^ {3{prev_d}}) : 3'b000;
      if (reset || start) begin
        mode[k] = reset ? 0 : 1;
        cyc[k] = 0; fc[k] = 0; er[k] = 0; fm[k] = 0;
        for (int j = 0; j < 3; j++) mis[k][j] = 0;
      end else if (mode[k] == 1 && stop) mode[k] = 0;
      else if (mode[k] == 1) begin
        old = cyc[k];
        if (cyc[k] < mx[k]) cyc[k]++;
        for (int j = 0; j < 3; j++) if (m[j] && mis[k][j] < mx[k]) mis[k][j]++;
        if (m != 0 && !er[k]) begin er[k] = 1; fm[k] = m; fc[k] = old; end
        if (hf[k] != 0 && m != 0) mode[k] = 2;
        else if (rl[k] != 0 && old == rl[k] - 1) begin mode[k] = 3; dn[k] = 1; end
      end
    end
    prev_d = reset ? 1'b0 : d_in;
  endtask
  function automatic logic [86:0] expv(int k);
    logic vote;
    vote = (q_sr + q_jk + q_t) >= 2;
    return {mode[k] == 1, dn[k], er[k], fm[k], 16'(fc[k]), 16'(cyc[k]),
            16'(mis[k][0]), 16'(mis[k][1]), 16'(mis[k][2]), vote};
  endfunction
  task automatic cyc_(input logic r, s, p, d, input logic [2:0] f, input logic raw);
    @(posedge clk); #1;
    step();
    reset = r; start = s; stop = p; d_in = d;
    {q_t, q_jk, q_sr} = raw ? f : ({3{prev_d}} ^ f);
    for (int k = 0; k < 3; k++) qe[k].push_back(expv(k));
  endtask
  always @(negedge clk)
    for (int k = 0; k < 3; k++)
      if (qe[k].size() > 0) begin
        logic [86:0] e;
        e = qe[k].pop_front();
        checks++;
        if (act[k] !== e) begin
          errors++;
          $display("FAIL u%0d outputs at %0t: got %h expected %h", k, $time, act[k], e);
        end
      end
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    logic [4:0] pat;
    pat = 5'b01101;
    for (int k = 0; k < 3; k++) mode[k] = 0;
    repeat (2) cyc_(1, 0, 0, 0, 0, 0);
    checks++;
    if ({act[0][86:1], act[1][86:1], act[2][86:1]} !== '0) begin
      errors++;
      $display("FAIL reset state at %0t: %h %h %h", $time, act[0], act[1], act[2]);
    end
    repeat (2) cyc_(0, 0, 0, 0, 0, 0);
    cyc_(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc_(0, 0, 0, pat[i], 0, 0);
    repeat (3) cyc_(0, 0, 0, 1, 0, 0);
    cyc_(0, 1, 0, 1, 0, 0);
    repeat (3) cyc_(0, 0, 0, 1, 0, 0);
    cyc_(0, 0, 0, 0, 3'b010, 0);
    repeat (3) cyc_(0, 0, 0, 0, 0, 0);
    cyc_(0, 1, 0, 1, 0, 0);
    repeat (2) cyc_(0, 0, 0, 1, 0, 0);
    repeat (4) cyc_(0, 0, 0, 1, 3'b100, 0);
    repeat (3) cyc_(0, 0, 0, 0, 0, 0);
    cyc_(0, 0, 0, 1, 3'b100, 0);
    cyc_(0, 0, 1, 0, 0, 0);
    cyc_(0, 1, 0, 0, 0, 0);
    repeat (20) cyc_(0, 0, 0, $urandom_range(0, 1), 3'b111, 0);
    cyc_(0, 0, 1, 0, 0, 0);
    cyc_(0, 1, 0, 1, 0, 0);
    repeat (3) cyc_(0, 0, 0, 1, 0, 0);
    cyc_(0, 1, 1, 0, 0, 0);
    repeat (2) cyc_(0, 0, 0, 1, 3'b001, 0);
    cyc_(1, 0, 0, 1, 0, 0);
    repeat (2) cyc_(0, 0, 0, 1, 0, 0);
    cyc_(0, 1, 0, 0, 0, 0);
    repeat (4) cyc_(0, 0, 0, 1, 0, 0);
    cyc_(0, 0, 1, 0, 0, 0);
    cyc_(0, 0, 0, 0, 3'b011, 1);
    cyc_(0, 0, 0, 1, 3'b010, 1);
    cyc_(0, 0, 0, 0, 3'b101, 1);
    cyc_(0, 0, 0, 1, 3'b100, 1);
    for (int i = 0; i < 500; i++)
      cyc_($urandom_range(0, 99) == 0, $urandom_range(0, 24) == 0, $urandom_range(0, 29) == 0,
           1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000, 0);
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
